// File: rtl/ro_freq_counter.sv
// ro_freq_counter: gated rising-edge counter for a thermal-sensor ring oscillator.
// Enables the RO, lets it settle, then counts synchronized edges over G clk cycles.
module ro_freq_counter #(
  parameter int COUNT_WIDTH   = 32,
  parameter int GATE_WIDTH    = 24,
  parameter int SETTLE_CYCLES = 16,
  parameter bit KEEP_ENABLED  = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [GATE_WIDTH-1:0]  gate_cycles,
  input  logic                   ro_out,
  output logic                   ro_enable,
  output logic                   busy,
  output logic                   count_valid,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  localparam int SW = $clog2(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    MEASURE,
    DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic s1;
  logic s2;
  logic s3;
  logic edge_hit;

  logic [SW-1:0]          settle_cnt;
  logic [GATE_WIDTH-1:0]  gate_cnt;
  logic [GATE_WIDTH-1:0]  gate_eff;
  logic [COUNT_WIDTH-1:0] acc;
  logic [COUNT_WIDTH-1:0] acc_nx;
  logic                   ovf_flag;
  logic                   ovf_nx;

  logic accept;
  logic settle_last;
  logic gate_last;

  assign edge_hit    = s2 & ~s3;
  assign accept      = (state == IDLE) && start;
  assign settle_last = settle_cnt == SW'(SETTLE_CYCLES - 1);
  assign gate_last   = gate_cnt == GATE_WIDTH'(1);
  assign gate_eff    = (gate_cycles == '0) ? GATE_WIDTH'(1)
                                           : gate_cycles;

  always_comb begin
    state_nx    = state;
    ro_enable   = KEEP_ENABLED;
    busy        = 1'b0;
    count_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = SETTLE;
      end
      SETTLE: begin
        ro_enable = 1'b1;
        busy      = 1'b1;
        if (settle_last) state_nx = MEASURE;
      end
      MEASURE: begin
        ro_enable = 1'b1;
        busy      = 1'b1;
        if (gate_last) state_nx = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        count_valid = 1'b1;
        state_nx    = IDLE;
      end
    endcase
  end

  // Saturating accumulate; an edge seen at all-ones only raises the flag.
  always_comb begin
    acc_nx = acc;
    ovf_nx = ovf_flag;
    if (state == MEASURE && edge_hit) begin
      if (&acc) ovf_nx = 1'b1;
      else      acc_nx = acc + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      settle_cnt <= '0;
      gate_cnt   <= '0;
      acc        <= '0;
      ovf_flag   <= 1'b0;
      count      <= '0;
      overflow   <= 1'b0;
    end else begin
      s1       <= ro_out;
      s2       <= s1;
      s3       <= s2;
      state    <= state_nx;
      acc      <= acc_nx;
      ovf_flag <= ovf_nx;
      if (accept) begin
        acc        <= '0;
        ovf_flag   <= 1'b0;
        gate_cnt   <= gate_eff;
        settle_cnt <= '0;
      end
      if (state == SETTLE) settle_cnt <= settle_cnt + 1'b1;
      if (state == MEASURE) gate_cnt <= gate_cnt - 1'b1;
      // Result lands on entry to DONE so it is visible with the pulse.
      if (state == MEASURE && gate_last) begin
        count    <= acc_nx;
        overflow <= ovf_nx;
      end
    end
  end

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb_ro_freq_counter: randomized and directed checks of ro_freq_counter.
// Expected counts come from a sampled-waveform edge model over the gate window.
module tb_ro_freq_counter;

  localparam int S  = 16;
  localparam int GW = 24;
  localparam int HN = 32768;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [GW-1:0] gate_cycles;
  logic          ro_out = 1'b0;

  logic        ro_enable_a;
  logic        busy_a;
  logic        valid_a;
  logic [31:0] count_a;
  logic        ovf_a;

  logic        ro_enable_b;
  logic        busy_b;
  logic        valid_b;
  logic [3:0]  count_b;
  logic        ovf_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ro_mode = 2;
  int hp   = 5;
  int ph   = 0;
  int dens = 50;
  int last_t = 0;
  longint last_n = 0;
  logic hist [0:HN-1];

  ro_freq_counter dut_a (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .gate_cycles (gate_cycles),
    .ro_out      (ro_out),
    .ro_enable   (ro_enable_a),
    .busy        (busy_a),
    .count_valid (valid_a),
    .count       (count_a),
    .overflow    (ovf_a)
  );

  ro_freq_counter #(
    .COUNT_WIDTH  (4),
    .KEEP_ENABLED (1'b1)
  ) dut_b (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .gate_cycles (gate_cycles),
    .ro_out      (ro_out),
    .ro_enable   (ro_enable_b),
    .busy        (busy_b),
    .count_valid (valid_b),
    .count       (count_b),
    .overflow    (ovf_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (cyc < HN) hist[cyc] = ro_out;
  end

  always @(negedge clk) begin
    case (ro_mode)
      0: if (ro_enable_a) begin
        ph = ph + 1;
        if (ph >= hp) begin
          ph = 0;
          ro_out = ~ro_out;
        end
      end
      1: ro_out = ($urandom_range(0, 99) < dens);
      default: ro_out = 1'b0;
    endcase
  end

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // Rising edges of the sampled RO seen during the gate window.
  function automatic longint model_edges(input int t, input int g);
    longint n = 0;
    for (int m = t + S; m <= t + S + g - 1; m++)
      if (hist[m] && !hist[m-1]) n++;
    return n;
  endfunction

  task automatic measure(input int g, input bit hold, input int poke);
    int t;
    int ge;
    int lat;
    bit ok_b;
    bit ok_e;
    longint n;
    n  = 0;
    t  = cyc;
    ge = (g == 0) ? 1 : g;
    gate_cycles = GW'(g);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    gate_cycles = GW'($urandom);
    lat  = -1;
    ok_b = 1'b1;
    ok_e = 1'b1;
    while (lat < 0 && cyc <= t + S + ge + 8) begin
      if (poke > 0 && cyc == t + poke) start = 1'b1;
      if (poke > 0 && cyc == t + poke + 1 && !hold) start = 1'b0;
      if (valid_a) lat = cyc - t;
      else begin
        if (!(busy_a && busy_b)) ok_b = 1'b0;
        if (!(ro_enable_a && ro_enable_b)) ok_e = 1'b0;
        @(negedge clk);
      end
    end
    chk("latency", lat, S + 1 + ge);
    chk("busy_win", ok_b, 1);
    chk("ren_win", ok_e, 1);
    if (lat >= 0) begin
      n = model_edges(t, ge);
      chk("cnt_a", count_a, n);
      chk("ovf_a", ovf_a, 0);
      chk("cnt_b", count_b, (n > 15) ? 15 : n);
      chk("ovf_b", ovf_b, n > 15);
      chk("done_busy", busy_a, 1);
      chk("done_ren_a", ro_enable_a, 0);
      chk("valid_b", valid_b, 1);
      @(negedge clk);
      chk("pulse_a", valid_a, 0);
      chk("idle_busy", busy_a, 0);
      chk("idle_ren", {ro_enable_a, ro_enable_b}, 2'b01);
      chk("hold_a", count_a, n);
    end
    last_t = t;
    last_n = n;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout got %0d exp %0d", cyc, 0);
    $fatal(1, "timeout");
  end

  initial begin
    int t1;
    bit seen;
    bit quiet;
    rst = 1'b1;
    start = 1'b0;
    gate_cycles = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_cnt", count_a, 0);
    chk("rst_ovf", ovf_a, 0);
    chk("rst_ren", {ro_enable_a, ro_enable_b}, 2'b01);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_keep", ro_enable_b, 1);

    // basic: period-10 square wave
    ro_mode = 0;
    hp = 5;
    measure(1000, 1'b0, 0);
    chk("basic_cnt", count_a, 100);

    // zero gate clamps to one cycle
    ro_mode = 2;
    repeat (3) @(negedge clk);
    measure(0, 1'b0, 0);
    chk("zero_cnt", count_a, 0);

    // saturation of the 4-bit instance
    ro_mode = 0;
    hp = 2;
    measure(100, 1'b0, 0);
    chk("sat_cnt_b", count_b, 15);
    chk("sat_ovf_b", ovf_b, 1);
    chk("sat_cnt_a", count_a, 25);
    measure(20, 1'b0, 0);
    chk("nosat_cnt_b", count_b, 5);
    chk("nosat_ovf_b", ovf_b, 0);

    // start during busy is ignored
    hp = 5;
    measure(1000, 1'b0, 50);
    quiet = 1'b1;
    repeat (30) begin
      if (busy_a || valid_a) quiet = 1'b0;
      @(negedge clk);
    end
    chk("busy_start_ignored", quiet, 1);

    // start held: back-to-back results
    measure(1000, 1'b1, 0);
    t1 = last_t;
    measure(1000, 1'b0, 0);
    chk("b2b_period", last_t - t1, 1018);
    chk("b2b_cnt", count_a, 100);

    // reset during MEASURE aborts
    gate_cycles = GW'(1000);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (S + 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy_a, 0);
    chk("abort_valid", valid_a, 0);
    chk("abort_ren", {ro_enable_a, ro_enable_b}, 2'b01);
    chk("abort_cnt", count_a, 0);
    chk("abort_ovf", {ovf_a, ovf_b}, 0);
    chk("abort_cnt_b", count_b, 0);
    seen = 1'b0;
    repeat (1000) begin
      if (valid_a || valid_b || busy_a) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_quiet", seen, 0);
    measure(1000, 1'b0, 0);
    chk("after_abort_cnt", count_a, 100);

    // randomized runs
    for (int i = 0; i < 14; i++) begin
      ro_mode = $urandom_range(0, 1);
      hp   = $urandom_range(1, 6);
      dens = $urandom_range(0, 100);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      measure($urandom_range(0, 200), 1'b0,
              ($urandom_range(0, 3) == 0) ? 5 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
